// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle EX-stage ALU with valid/ready handshakes on operands and result.
// Define SERIAL_SHIFT_EN to shift serially, one bit per cycle through the SHIFT state.
// Leave it undefined to use a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   alu_sel,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         busy
);
  localparam int SW = $clog2(N);
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DONE  = 2'd1
`ifdef SERIAL_SHIFT_EN
    ,S_SHIFT = 2'd2
`endif
  } state_t;

  state_t         r_state;
  state_t         w_state_nx;
  logic [N-1:0]   r_result;
  logic           r_zero;
  logic           w_accept;
  logic           w_is_shift;
  logic           w_go_shift;
  logic [SW-1:0]  w_amt;
  logic [N-1:0]   w_sh;
  logic [N-1:0]   w_res;
  logic           w_slt;
  logic           w_sltu;

  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_amt      = op_b[SW-1:0];
  assign w_is_shift = (alu_sel == ALU_SLL) || (alu_sel == ALU_SRL) || (alu_sel == ALU_SRA);
  assign w_slt      = $signed(op_a) < $signed(op_b);
  assign w_sltu     = op_a < op_b;

`ifdef SERIAL_SHIFT_EN
  localparam logic [SW-1:0] CNT_ONE = SW'(1);
  logic [N-1:0]  r_acc;
  logic [SW-1:0] r_cnt;
  logic [3:0]    r_sel;
  logic [N-1:0]  w_acc_nx;
  logic          w_shift_last;

  // A zero-amount shift completes straight from IDLE with op_a unchanged
  assign w_sh         = op_a;
  assign w_go_shift   = w_is_shift && (w_amt != '0);
  assign w_shift_last = (r_state == S_SHIFT) && (r_cnt == CNT_ONE);
  assign w_acc_nx     = (r_sel == ALU_SLL) ? {r_acc[N-2:0], 1'b0}
                                           : {(r_sel == ALU_SRA) & r_acc[N-1], r_acc[N-1:1]};

  // Serial shifter: load on accept, one bit per cycle while in SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sel <= '0;
    end else if (w_accept && w_go_shift) begin
      r_acc <= op_a;
      r_cnt <= w_amt;
      r_sel <= alu_sel;
    end else if (r_state == S_SHIFT) begin
      r_acc <= w_acc_nx;
      r_cnt <= r_cnt - CNT_ONE;
    end
  end
`else
  assign w_go_shift = 1'b0;
  assign w_sh = (alu_sel == ALU_SLL) ? (op_a << w_amt)
              : (alu_sel == ALU_SRL) ? (op_a >> w_amt)
              : N'($signed(op_a) >>> w_amt);
`endif

  assign w_res = (alu_sel == ALU_ADD)  ? op_a + op_b
               : (alu_sel == ALU_SUB)  ? op_a - op_b
               : (alu_sel == ALU_AND)  ? op_a & op_b
               : (alu_sel == ALU_OR)   ? op_a | op_b
               : (alu_sel == ALU_SLT)  ? {{(N-1){1'b0}}, w_slt}
               : (alu_sel == ALU_SLTU) ? {{(N-1){1'b0}}, w_sltu}
               : w_is_shift            ? w_sh
               : '0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state decode; handshake outputs depend on state only
  always_comb begin
    w_state_nx = r_state;
    in_ready   = (r_state == S_IDLE);
    out_valid  = (r_state == S_DONE);
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  w_state_nx = !in_valid ? S_IDLE
`ifdef SERIAL_SHIFT_EN
                          : w_go_shift ? S_SHIFT
`endif
                          : S_DONE;
`ifdef SERIAL_SHIFT_EN
      S_SHIFT: w_state_nx = w_shift_last ? S_DONE : S_SHIFT;
`endif
      S_DONE:  w_state_nx = out_ready ? S_IDLE : S_DONE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Result register: written on a single-cycle accept or on the final shift step, held in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_accept && !w_go_shift) begin
      r_result <= w_res;
      r_zero   <= (w_res == '0);
`ifdef SERIAL_SHIFT_EN
    end else if (w_shift_last) begin
      r_result <= w_acc_nx;
      r_zero   <= (w_acc_nx == '0);
`endif
    end
  end

  assign result = r_result;
  assign zero   = r_zero;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit (serial or barrel build).
module tb_alu_exec_unit;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
`ifdef SERIAL_SHIFT_EN
  localparam bit SER = 1'b1;
`else
  localparam bit SER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;
  int          checks = 0;
  int          errors = 0;

  alu_exec_unit #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure latency in cycles (1 = out_valid the cycle after accept), check, drain
  task automatic do_op(input string tag, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int n;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    alu_sel  = s;
    op_a     = a;
    op_b     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_result"}, result, exp);
    chk({tag, "_zero"}, 32'(zero), 32'(exp == 32'd0));
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drained_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_drained_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_sel = '0; op_a = '0; op_b = '0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_op("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1);
    do_op("sub_zero", ALU_SUB, 32'd5, 32'd5, 32'd0, 1);
    do_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    do_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    do_op("and", ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
    do_op("or", ALU_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1);
    do_op("sra4", ALU_SRA, 32'h8000_0000, 32'h0000_0104, 32'hF800_0000, SER ? 5 : 1);
    do_op("sll0", ALU_SLL, 32'h0000_00A5, 32'h0000_0000, 32'h0000_00A5, 1);
    do_op("sll31", ALU_SLL, 32'h0000_0003, 32'h0000_003F, 32'h8000_0000, SER ? 32 : 1);
    do_op("srl1", ALU_SRL, 32'h8000_0001, 32'h0000_0021, 32'h4000_0000, SER ? 2 : 1);
    do_op("sra_pos", ALU_SRA, 32'h7000_0000, 32'h0000_0008, 32'h0070_0000, SER ? 9 : 1);
    do_op("unknown", 4'hF, 32'h1234_5678, 32'h1111_1111, 32'd0, 1);

    // DONE holds while the consumer stalls; a pending in_valid is not taken
    in_valid = 1'b1; alu_sel = ALU_ADD; op_a = 32'd10; op_b = 32'd20;
    @(posedge clk); #1;
    op_a = 32'd100; op_b = 32'd200;
    chk("hold_first_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_result", result, 32'd30);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_release_ready", 32'(in_ready), 32'd1);
    chk("hold_release_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hold_next_valid", 32'(out_valid), 32'd1);
    chk("hold_next_result", result, 32'd300);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_next_drained", 32'(in_ready), 32'd1);

    // Asynchronous reset part-way through a long shift drops the op immediately
    in_valid = 1'b1; alu_sel = ALU_SRL; op_a = 32'hFFFF_FFFF; op_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    chk("midrst_valid_before", 32'(out_valid), SER ? 32'd0 : 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_zero", 32'(zero), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("midrst_held_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    do_op("post_rst_add", ALU_ADD, 32'd2, 32'd3, 32'd5, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execute unit that consumes the 4-bit `ALUSel` code produced by the ALU control decoder and performs the selected operation on two N-bit operands. It sits in the EX stage between the operand muxes (ALUSrc path) and the writeback/branch logic. A valid/ready handshake runs on both the operand side and the result side. Shifts optionally execute serially, one bit per cycle, to save area.

## Interface
Parameters:
- `N`, 32, operand/result width; power of two, ≥ 8
- `SW`, `$clog2(N)`, shift-amount width (derived, not overridden)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operands and `alu_sel` are valid
- `in_ready`  out  1  unit can accept an operation; high iff state = IDLE
- `alu_sel`  in  4  operation code, `ALU_*` encodings from defines.v
- `op_a`  in  N  first operand / shift source
- `op_b`  in  N  second operand; `op_b[SW-1:0]` is the shift amount
- `out_valid`  out  1  `result`/`zero` valid; high iff state = DONE
- `out_ready`  in  1  consumer takes the result
- `result`  out  N  registered result
- `zero`  out  1  registered; 1 iff `result == 0`
- `busy`  out  1  high iff state ≠ IDLE

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: accept on `in_valid && in_ready`. Capture `alu_sel`, `op_a`, `op_b`.
  - Non-shift op: compute, register `result`/`zero`, go to DONE.
  - Shift op, serial mode: load `acc = op_a`, `cnt = op_b[SW-1:0]`. If `cnt == 0`, register `result = op_a` and go to DONE; else go to SHIFT.
- SHIFT: each cycle shift `acc` by 1 and decrement `cnt`.
  - SLL fills with 0; SRL fills with 0; SRA fills with `acc[N-1]`.
  - When `cnt == 1`, write the shifted value to `result`/`zero` and go to DONE.
  - `in_valid` is ignored in SHIFT.
- DONE: hold `result` and `zero` stable. On `out_ready`, go to IDLE. No new operation is accepted in DONE.
- Operations:
  - ADD, SUB: modulo 2^N; carry/overflow discarded.
  - AND, OR: bitwise.
  - SLT: signed compare. SLTU: unsigned compare. Result is {N-1 zeros, lt}.
  - SLL, SRL, SRA: shift amount uses only `op_b[SW-1:0]`; upper bits ignored.
  - Any other code: `result = 0`, `zero = 1`, still completes through DONE.
- Reset (asynchronous, at any time including mid-SHIFT or DONE):
  - state = IDLE, `result = 0`, `zero = 0`, `out_valid = 0`, `busy = 0`, internal `acc`/`cnt` = 0.
  - `in_ready = 1` while reset is asserted. Any in-flight operation is dropped.

## Timing
- Accept edge k (non-shift, or shift with amount 0, or any shift with macro off): `out_valid` is high in the cycle after edge k. Latency is 1.
- Shift with amount s ≥ 1 (serial mode): SHIFT occupies edges k+1 … k+s; `out_valid` rises after edge k+s. Latency is s+1 cycles.
- Result leaves on edge m where `out_valid && out_ready`. `in_ready` rises after edge m, so the earliest next accept is edge m+1.
- Maximum throughput is one op per 2 cycles.
- `out_valid` may wait indefinitely for `out_ready`; outputs do not change while waiting.
- `in_ready` and `out_valid` are decoded from state only, with no combinational path from `in_valid` or `out_ready`.

## Configuration
- `SERIAL_SHIFT_EN` defined: SLL/SRL/SRA use the SHIFT state and the `acc`/`cnt` registers, latency s+1.
- `SERIAL_SHIFT_EN` undefined: a single-cycle barrel shifter is used. All ops have latency 1, the SHIFT state and `acc`/`cnt` are not built, and results are bit-identical to the serial mode.

## Test plan
- ADD `op_a`=32'h7FFF_FFFF, `op_b`=1 → `result`=32'h8000_0000, `zero`=0, `out_valid` 1 cycle after accept. SUB 5−5 → `result`=0, `zero`=1.
- SLT `op_a`=32'hFFFF_FFFF, `op_b`=1 → `result`=1. SLTU with the same operands → `result`=0.
- SRA `op_a`=32'h8000_0000, `op_b`=32'h0000_0104 (amount 4) → `result`=32'hF800_0000. With the macro defined, `out_valid` rises exactly 4 edges after accept and `busy` is high throughout.
- SLL amount 0, `op_a`=32'hA5 → `result`=32'hA5, latency 1 in both configurations. Unknown `alu_sel` → `result`=0, `zero`=1.
- Hold `out_ready`=0 for 10 cycles in DONE while `in_valid`=1 with new operands → `result` stable, `in_ready`=0, nothing accepted. Raise `out_ready` → IDLE, and the new op is accepted one cycle later.
- Assert `rst_n`=0 mid-SHIFT of SRL amount 20 → `out_valid`=0, `result`=0, `busy`=0 immediately. After release, a fresh ADD 2+3 returns 5.
